dmac_master_ctrl: RTL and testbench

//  Transfer sequencer (bus-master side) of the DMAC. Pops descriptors (src, dest, size) from the

---
 rtl/dmac_master_ctrl.sv | 156 +++++++++++++++
 tb/tb_dmac_master_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_master_ctrl.sv
// DMAC bus-master transfer sequencer: pops descriptors and copies one word per
// READ/LATCH/WRITE pass, releasing the bus between descriptors.
module dmac_master_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_start,
  input  logic              op_clear,
  input  logic [2:0]        op_mode,
  input  logic              desc_empty,
  output logic              desc_rd_en,
  input  logic [ADDR_W-1:0] desc_src,
  input  logic [ADDR_W-1:0] desc_dest,
  input  logic [DATA_W-1:0] desc_size,
  output logic              M_req,
  input  logic              M_grant,
  output logic              M_wr,
  output logic [ADDR_W-1:0] M_address,
  output logic [DATA_W-1:0] M_dout,
  input  logic [DATA_W-1:0] M_din,
  output logic              op_done,
  output logic [2:0]        next_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    POP   = 3'b001,
    LOAD  = 3'b010,
    REQ   = 3'b011,
    READ  = 3'b100,
    LATCH = 3'b101,
    WRITE = 3'b110,
    DONE  = 3'b111
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ONE_D  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_src_q, cur_src_d;
  logic [ADDR_W-1:0] cur_dest_q, cur_dest_d;
  logic [DATA_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] data_buf_q, data_buf_d;
  logic              desc_rd_en_q, desc_rd_en_d;
  logic              m_req_q, m_req_d;
  logic              m_wr_q, m_wr_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic [DATA_W-1:0] m_dout_q, m_dout_d;
  logic              op_done_q, op_done_d;
  logic              mode_unused;

  assign mode_unused = op_mode[2];

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cur_src_d   = cur_src_q;
    cur_dest_d  = cur_dest_q;
    remaining_d = remaining_q;
    data_buf_d  = data_buf_q;
    case (state_q)
      IDLE: begin
        if (op_start && !desc_empty) state_d = POP;
        else if (op_start)           state_d = DONE;
        else                         state_d = IDLE;
      end
      POP: state_d = LOAD;
      LOAD: begin
        cur_src_d   = desc_src;
        cur_dest_d  = desc_dest;
        remaining_d = desc_size;
        if (desc_size != ZERO_D) state_d = REQ;
        else if (!desc_empty)    state_d = POP;
        else                     state_d = DONE;
      end
      REQ: begin
        if (M_grant) state_d = READ;
        else         state_d = REQ;
      end
      READ: state_d = LATCH;
      LATCH: begin
        data_buf_d = M_din;
        state_d    = WRITE;
      end
      WRITE: begin
        remaining_d = remaining_q - ONE_D;
        cur_src_d   = op_mode[0] ? cur_src_q : cur_src_q + ONE_A;
        cur_dest_d  = op_mode[1] ? cur_dest_q : cur_dest_q + ONE_A;
        if (remaining_q != ONE_D) state_d = READ;
        else if (!desc_empty)     state_d = POP;
        else                      state_d = DONE;
      end
      DONE: begin
        if (op_clear) state_d = IDLE;
        else          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the upcoming state, so registered outputs track state_q exactly
  always_comb begin
    desc_rd_en_d = (state_d == POP);
    m_req_d      = (state_d == REQ) || (state_d == READ) || (state_d == LATCH) || (state_d == WRITE);
    m_wr_d       = (state_d == WRITE);
    op_done_d    = (state_d == DONE);
    if (state_d == READ)       m_address_d = cur_src_d;
    else if (state_d == WRITE) m_address_d = cur_dest_d;
    else                       m_address_d = ZERO_A;
    if (state_d == WRITE) m_dout_d = data_buf_d;
    else                  m_dout_d = ZERO_D;
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cur_src_q    <= ZERO_A;
      cur_dest_q   <= ZERO_A;
      remaining_q  <= ZERO_D;
      data_buf_q   <= ZERO_D;
      desc_rd_en_q <= 1'b0;
      m_req_q      <= 1'b0;
      m_wr_q       <= 1'b0;
      m_address_q  <= ZERO_A;
      m_dout_q     <= ZERO_D;
      op_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_src_q    <= cur_src_d;
      cur_dest_q   <= cur_dest_d;
      remaining_q  <= remaining_d;
      data_buf_q   <= data_buf_d;
      desc_rd_en_q <= desc_rd_en_d;
      m_req_q      <= m_req_d;
      m_wr_q       <= m_wr_d;
      m_address_q  <= m_address_d;
      m_dout_q     <= m_dout_d;
      op_done_q    <= op_done_d;
    end
  end

  assign desc_rd_en = desc_rd_en_q;
  assign M_req      = m_req_q;
  assign M_wr       = m_wr_q;
  assign M_address  = m_address_q;
  assign M_dout     = m_dout_q;
  assign op_done    = op_done_q;
  // Reset forces the exported next state to IDLE so the slave never sees a stray POP
  assign next_state = reset_n ? state_d : IDLE;

endmodule

// File: tb/tb_dmac_master_ctrl.sv
// Randomized bench for dmac_master_ctrl: a transaction-level model walks each job
// descriptor by descriptor and word by word, and a compare process checks every cycle.
module tb_dmac_master_ctrl;

  localparam logic [2:0] S_IDLE = 3'b000, S_POP = 3'b001, S_LOAD = 3'b010, S_REQ = 3'b011;
  localparam logic [2:0] S_READ = 3'b100, S_LATCH = 3'b101, S_WRITE = 3'b110, S_DONE = 3'b111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_start = 1'b0, op_clear = 1'b0;
  logic [2:0]  op_mode = 3'd0;
  logic        desc_empty = 1'b1;
  logic [31:0] desc_src = 32'd0, desc_dest = 32'd0, desc_size = 32'd0;
  logic        M_grant = 1'b0;
  logic [31:0] M_din = 32'd0;
  logic        desc_rd_en, M_req, M_wr, op_done;
  logic [31:0] M_address, M_dout;
  logic [2:0]  next_state;

  dmac_master_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
    .op_mode(op_mode), .desc_empty(desc_empty), .desc_rd_en(desc_rd_en),
    .desc_src(desc_src), .desc_dest(desc_dest), .desc_size(desc_size),
    .M_req(M_req), .M_grant(M_grant), .M_wr(M_wr), .M_address(M_address),
    .M_dout(M_dout), .M_din(M_din), .op_done(op_done), .next_state(next_state)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] src, dest, size; } desc_t;
  typedef struct packed { logic rd, req, wr, done, chk_addr; logic [31:0] addr, dout; } exp_t;

  desc_t       fifo[$];
  exp_t        e;
  logic [2:0]  e_ns = 3'd0;
  bit          chk_en = 1'b0;
  int          checks = 0, failures = 0;
  logic [63:0] wlog[$];
  int          npop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic rd, req, wr, done, ca, input logic [31:0] a, d);
    exp_t x;
    x.rd = rd; x.req = req; x.wr = wr; x.done = done; x.chk_addr = ca; x.addr = a; x.dout = d;
    return x;
  endfunction

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  // Per-cycle comparison of the DUT against the model expectation
  always @(negedge clk) begin
    if (chk_en) begin
      chk("next_state", {29'd0, next_state}, {29'd0, e_ns});
      chk("desc_rd_en", {31'd0, desc_rd_en}, {31'd0, e.rd});
      chk("M_req", {31'd0, M_req}, {31'd0, e.req});
      chk("M_wr", {31'd0, M_wr}, {31'd0, e.wr});
      chk("op_done", {31'd0, op_done}, {31'd0, e.done});
      if (e.chk_addr) chk("M_address", M_address, e.addr);
      if (e.wr) chk("M_dout", M_dout, e.dout);
      if (M_req && M_wr) wlog.push_back({M_address, M_dout});
      if (desc_rd_en) npop++;
    end
  end

  // One clock of the model: outputs of the current state and the transition it takes
  task automatic tick(input exp_t x, input logic [2:0] ns);
    e = x; e_ns = ns;
    desc_empty = (fifo.size() == 0);
    @(posedge clk); #1;
  endtask

  task automatic push_desc(input logic [31:0] s, d, n);
    desc_t x;
    x.src = s; x.dest = d; x.size = n;
    fifo.push_back(x);
  endtask

  task automatic reset_mid();
    chk_en = 1'b0;
    op_start = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid M_req", {31'd0, M_req}, 32'd0);
    chk("rst_mid M_wr", {31'd0, M_wr}, 32'd0);
    chk("rst_mid M_address", M_address, 32'd0);
    chk("rst_mid M_dout", M_dout, 32'd0);
    chk("rst_mid op_done", {31'd0, op_done}, 32'd0);
    chk("rst_mid next_state", {29'd0, next_state}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    fifo.delete();
    chk_en = 1'b1;
    repeat (4) tick(mk(0, 0, 0, 0, 1, 32'd0, 32'd0), S_IDLE);
  endtask

  task automatic run_job(input logic [2:0] mode, input int gmin, input int gmax, input int abort_word);
    desc_t d;
    int wn, nd;
    logic [31:0] ra, wa;
    op_mode = mode; op_start = 1'b1; op_clear = 1'($urandom); M_grant = 1'($urandom);
    tick(mk(0, 0, 0, 0, 1, 32'd0, 32'd0), (fifo.size() == 0) ? S_DONE : S_POP);
    while (fifo.size() != 0) begin
      op_start = 1'($urandom); op_clear = 1'($urandom); M_grant = 1'($urandom);
      tick(mk(1, 0, 0, 0, 1, 32'd0, 32'd0), S_LOAD);
      d = fifo.pop_front();
      desc_src = d.src; desc_dest = d.dest; desc_size = d.size;
      op_clear = 1'($urandom); M_grant = 1'($urandom);
      tick(mk(0, 0, 0, 0, 1, 32'd0, 32'd0),
           (d.size != 32'd0) ? S_REQ : ((fifo.size() != 0) ? S_POP : S_DONE));
      desc_src = $urandom; desc_dest = $urandom; desc_size = $urandom;
      if (d.size == 32'd0) continue;
      wn = $urandom_range(gmax, gmin);
      M_grant = 1'b0;
      for (int i = 0; i < wn; i++) tick(mk(0, 1, 0, 0, 1, 32'd0, 32'd0), S_REQ);
      M_grant = 1'b1;
      tick(mk(0, 1, 0, 0, 1, 32'd0, 32'd0), S_READ);
      for (int k = 0; k < int'(d.size); k++) begin
        ra = d.src + (mode[0] ? 32'd0 : 32'(k));
        wa = d.dest + (mode[1] ? 32'd0 : 32'(k));
        op_start = 1'($urandom); op_clear = 1'($urandom); M_din = $urandom;
        tick(mk(0, 1, 0, 0, 1, ra, 32'd0), S_LATCH);
        M_din = mem(ra);
        tick(mk(0, 1, 0, 0, 0, 32'd0, 32'd0), S_WRITE);
        M_din = $urandom;
        if (k == abort_word) begin
          reset_mid();
          return;
        end
        tick(mk(0, 1, 1, 0, 1, wa, mem(ra)),
             (k == int'(d.size) - 1) ? ((fifo.size() == 0) ? S_DONE : S_POP) : S_READ);
      end
    end
    op_clear = 1'b0;
    nd = $urandom_range(3, 1);
    repeat (nd) begin
      op_start = 1'($urandom); M_grant = 1'($urandom);
      tick(mk(0, 0, 0, 1, 1, 32'd0, 32'd0), S_DONE);
    end
    op_clear = 1'b1;
    tick(mk(0, 0, 0, 1, 1, 32'd0, 32'd0), S_IDLE);
    op_clear = 1'b0; op_start = 1'b0;
    tick(mk(0, 0, 0, 0, 1, 32'd0, 32'd0), S_IDLE);
  endtask

  task automatic chk_write(input int i, input logic [31:0] a, input logic [31:0] dv);
    if (i < wlog.size()) begin
      chk("lit write addr", wlog[i][63:32], a);
      chk("lit write data", wlog[i][31:0], dv);
    end else begin
      chk("lit write missing", 32'(wlog.size()), 32'(i + 1));
    end
  endtask

  initial begin
    int nd;
    logic [31:0] s;
    e = mk(0, 0, 0, 0, 1, 32'd0, 32'd0);
    op_start = 1'b1; desc_empty = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset next_state", {29'd0, next_state}, 32'd0);
    chk("reset M_req", {31'd0, M_req}, 32'd0);
    chk("reset desc_rd_en", {31'd0, desc_rd_en}, 32'd0);
    chk("reset op_done", {31'd0, op_done}, 32'd0);
    chk("reset M_address", M_address, 32'd0);
    op_start = 1'b0;
    reset_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) tick(mk(0, 0, 0, 0, 1, 32'd0, 32'd0), S_IDLE);

    // Single descriptor, three words
    wlog.delete(); npop = 0;
    push_desc(32'h10, 32'h20, 32'd3);
    run_job(3'b000, 0, 0, -1);
    chk("t1 writes", 32'(wlog.size()), 32'd3);
    chk_write(0, 32'h20, 32'h110);
    chk_write(1, 32'h21, 32'h111);
    chk_write(2, 32'h22, 32'h112);
    chk("t1 pops", 32'(npop), 32'd1);

    // Two descriptors
    wlog.delete(); npop = 0;
    push_desc(32'h10, 32'h20, 32'd2);
    push_desc(32'h40, 32'h50, 32'd1);
    run_job(3'b000, 0, 1, -1);
    chk("t2 writes", 32'(wlog.size()), 32'd3);
    chk_write(2, 32'h50, 32'h140);
    chk("t2 pops", 32'(npop), 32'd2);

    // Fixed source address
    wlog.delete();
    push_desc(32'h10, 32'h20, 32'd4);
    run_job(3'b001, 0, 0, -1);
    chk_write(0, 32'h20, 32'h110);
    chk_write(3, 32'h23, 32'h110);

    // Grant withheld five cycles
    push_desc(32'h30, 32'h60, 32'd1);
    run_job(3'b000, 5, 5, -1);

    // Empty FIFO, then a zero-size descriptor
    wlog.delete(); npop = 0;
    run_job(3'b000, 0, 0, -1);
    push_desc(32'h70, 32'h80, 32'd0);
    run_job(3'b000, 0, 0, -1);
    chk("t5 writes", 32'(wlog.size()), 32'd0);
    chk("t5 pops", 32'(npop), 32'd1);

    // Reset during the second write of four
    wlog.delete();
    push_desc(32'h10, 32'h20, 32'd4);
    run_job(3'b000, 0, 0, 1);
    chk("t6 writes", 32'(wlog.size()), 32'd1);

    // Address wrap with fixed destination
    wlog.delete();
    push_desc(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd3);
    run_job(3'b110, 0, 2, -1);
    chk_write(2, 32'hFFFF_FFFE, 32'h0000_0101);

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      nd = $urandom_range(3, 0);
      for (int n = 0; n < nd; n++) begin
        s = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFE : $urandom;
        push_desc(s, $urandom, 32'($urandom_range(4, 0)));
      end
      run_job(3'($urandom), 0, 3, -1);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
